apb_pvt_scan_ctrl: RTL and testbench

//  Parametrised APB slave that autonomously scans NUM_CH PVT sensor channels.
//  One channel at a time: enable the sensor, wait for valid (or timeout), latch
//  the code, check it against per-channel hi/lo thresholds and raise a maskable
//  irq. Sits between the APB fabric and the P/V/T sensor macros. Adds masked
//  one-shot and periodic scanning to the per-group register sensor interface.

---
 rtl/apb_pvt_scan_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_apb_pvt_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pvt_scan_ctrl.sv
// APB slave that scans the masked PVT sensor channels in ascending order, latches
// each code, checks it against per-channel hi/lo thresholds and raises a maskable irq.
module apb_pvt_scan_ctrl #(
   parameter int  NUM_CH  = 8,
   parameter int  DATA_W  = 12,
   parameter int  TIMEOUT = 255,
   localparam int APB_AW  = $clog2(32 + NUM_CH*8)
) (
   input  logic                     s_apb_clk,
   input  logic                     s_apb_rst,
   input  logic [APB_AW-1:0]        s_apb_addr,
   input  logic                     s_apb_sel,
   input  logic                     s_apb_enable,
   input  logic                     s_apb_write,
   input  logic [31:0]              s_apb_wdata,
   input  logic [3:0]               s_apb_wstrb,
   output logic [31:0]              s_apb_rdata,
   output logic                     s_apb_ready,
   output logic                     s_apb_slverr,
   output logic [NUM_CH-1:0]        sens_en,
   input  logic [NUM_CH-1:0]        sens_valid,
   input  logic [NUM_CH*DATA_W-1:0] sens_data,
   output logic                     irq
);
   localparam int CNT_W = ($clog2(TIMEOUT+1) > 16) ? $clog2(TIMEOUT+1) : 16;
   localparam int CO_W  = APB_AW - 3;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_NEXT, S_WAIT} state_t;
   state_t r_state, w_state_nxt;

   logic                          r_en, r_cont, r_irq, r_empty;
   logic [15:0]                   r_mask, r_period;
   logic [31:0]                   r_irq_en, r_irq_stat;
   logic [3:0]                    r_ch;
   logic [CNT_W-1:0]              r_cnt;
   logic [NUM_CH-1:0][DATA_W-1:0] r_data;
   logic [NUM_CH-1:0][31:0]       r_thr;

   logic              w_acc, w_lo, w_ch_ok, w_err, w_wok, w_unused;
   logic              w_ctrl_wr, w_per_wr, w_ien_wr, w_ist_wr, w_thr_wr;
   logic [2:0]        w_reg;
   logic [CO_W-1:0]   w_ch_off;
   logic [3:0]        w_sel_ch, w_first, w_after;
   logic              w_first_ok, w_after_ok, w_en_nxt, w_cont_nxt, w_start;
   logic [15:0]       w_mask_nxt;
   logic              w_cur_valid, w_viol;
   logic [DATA_W-1:0] w_cur_data;
   logic [31:0]       w_cur_thr, w_hw_set, w_clr, w_rdata;
   logic              w_latch, w_tmo, w_done, w_go, w_adv, w_cnt_inc, w_cnt_clr;

   // Address decode: low window holds the control block, 8-byte slots above it per channel
   assign w_acc     = s_apb_sel & s_apb_enable;
   assign w_lo      = (s_apb_addr < APB_AW'(32));
   assign w_reg     = s_apb_addr[4:2];
   assign w_ch_off  = s_apb_addr[APB_AW-1:3] - CO_W'(4);
   assign w_ch_ok   = !w_lo && (w_ch_off < CO_W'(NUM_CH));
   assign w_sel_ch  = 4'(w_ch_off);
   assign w_err     = w_acc & (w_lo ? ((w_reg > 3'd4) | (s_apb_write & (w_reg == 3'd1)))
                                    : (!w_ch_ok | (s_apb_write & !s_apb_addr[2])));
   assign w_wok     = w_acc & s_apb_write & ~w_err;
   assign w_ctrl_wr = w_wok & w_lo & (w_reg == 3'd0);
   assign w_per_wr  = w_wok & w_lo & (w_reg == 3'd2);
   assign w_ien_wr  = w_wok & w_lo & (w_reg == 3'd3);
   assign w_ist_wr  = w_wok & w_lo & (w_reg == 3'd4);
   assign w_thr_wr  = w_wok & !w_lo & s_apb_addr[2];
   assign w_unused  = ^{s_apb_wstrb, s_apb_addr[1:0]};

   // A CTRL write takes effect in the same cycle it commits
   assign w_en_nxt   = w_ctrl_wr ? s_apb_wdata[0] : r_en;
   assign w_cont_nxt = w_ctrl_wr ? s_apb_wdata[2] : r_cont;
   assign w_mask_nxt = w_ctrl_wr ? s_apb_wdata[31:16] : r_mask;
   assign w_start    = w_ctrl_wr & s_apb_wdata[1] & s_apb_wdata[0];

   always_comb begin
      w_cur_valid = 1'b0;
      w_cur_data  = '0;
      w_cur_thr   = '0;
      w_first     = '0;
      w_first_ok  = 1'b0;
      w_after     = '0;
      w_after_ok  = 1'b0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (r_ch == 4'(i)) begin
            w_cur_valid = sens_valid[i];
            w_cur_data  = sens_data[i*DATA_W +: DATA_W];
            w_cur_thr   = r_thr[i];
         end
         if (w_mask_nxt[i]) begin
            w_first    = 4'(i);
            w_first_ok = 1'b1;
         end
         if (r_mask[i] && (4'(i) > r_ch)) begin
            w_after    = 4'(i);
            w_after_ok = 1'b1;
         end
      end
   end

   assign w_viol = (16'(w_cur_data) > w_cur_thr[31:16]) | (16'(w_cur_data) < w_cur_thr[15:0]);

   always_ff @(posedge s_apb_clk or posedge s_apb_rst) begin
      if (s_apb_rst) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_tmo       = 1'b0;
      w_done      = 1'b0;
      w_go        = 1'b0;
      w_adv       = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cnt_clr   = 1'b0;
      case (r_state)
         S_IDLE: if (w_start) begin
            w_state_nxt = S_CONV;
            w_go        = 1'b1;
         end
         S_CONV: begin
            if (r_empty) w_state_nxt = S_NEXT;
            else if (w_cur_valid) begin
               w_latch     = 1'b1;
               w_state_nxt = S_NEXT;
            end else if (r_cnt == CNT_W'(TIMEOUT)) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_NEXT;
            end else w_cnt_inc = 1'b1;
         end
         S_NEXT: begin
            if (w_after_ok) begin
               w_state_nxt = S_CONV;
               w_adv       = 1'b1;
            end else begin
               w_done      = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = w_cont_nxt ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt == CNT_W'(r_period)) begin
               w_state_nxt = S_CONV;
               w_go        = 1'b1;
            end else w_cnt_inc = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Dropping en aborts the scan outright: no data latch, no status bits
      if (r_state != S_IDLE && !w_en_nxt) begin
         w_state_nxt = S_IDLE;
         w_latch     = 1'b0;
         w_tmo       = 1'b0;
         w_done      = 1'b0;
         w_go        = 1'b0;
         w_adv       = 1'b0;
      end
   end

   always_comb begin
      w_hw_set     = '0;
      w_hw_set[30] = w_done;
      w_hw_set[29] = w_tmo;
      for (int i = 0; i < NUM_CH; i++)
         if (w_latch && w_viol && (r_ch == 4'(i))) w_hw_set[i] = 1'b1;
   end
   assign w_clr = w_ist_wr ? s_apb_wdata : '0;

   always_ff @(posedge s_apb_clk or posedge s_apb_rst) begin
      if (s_apb_rst) begin
         r_en       <= 1'b0;
         r_cont     <= 1'b0;
         r_mask     <= '0;
         r_period   <= '0;
         r_irq_en   <= '0;
         r_irq_stat <= '0;
         r_irq      <= 1'b0;
         r_ch       <= '0;
         r_empty    <= 1'b0;
         r_cnt      <= '0;
         r_data     <= '0;
         r_thr      <= {NUM_CH{32'hFFFF_0000}};
      end else begin
         if (w_ctrl_wr) begin
            r_en   <= s_apb_wdata[0];
            r_cont <= s_apb_wdata[2];
            r_mask <= s_apb_wdata[31:16];
         end
         if (w_per_wr) r_period <= s_apb_wdata[15:0];
         if (w_ien_wr) r_irq_en <= s_apb_wdata;
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_thr_wr && (w_sel_ch == 4'(i))) r_thr[i] <= s_apb_wdata;
            if (w_latch && (r_ch == 4'(i)))      r_data[i] <= w_cur_data;
         end
         if (w_go) begin
            r_ch    <= w_first;
            r_empty <= !w_first_ok;
            r_cnt   <= CNT_W'(1);
         end else if (w_adv) begin
            r_ch    <= w_after;
            r_empty <= 1'b0;
            r_cnt   <= CNT_W'(1);
         end else if (w_cnt_clr) r_cnt <= '0;
         else if (w_cnt_inc)     r_cnt <= r_cnt + CNT_W'(1);
         // Hardware set beats a simultaneous W1C clear
         r_irq_stat <= (r_irq_stat & ~w_clr) | w_hw_set;
         r_irq      <= |(r_irq_stat & r_irq_en);
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_acc && !s_apb_write && !w_err) begin
         if (w_lo) begin
            case (w_reg)
               3'd0:    w_rdata = {r_mask, 13'd0, r_cont, 1'b0, r_en};
               3'd1:    w_rdata = {20'd0, r_ch, 7'd0, (r_state != S_IDLE)};
               3'd2:    w_rdata = {16'd0, r_period};
               3'd3:    w_rdata = r_irq_en;
               3'd4:    w_rdata = r_irq_stat;
               default: w_rdata = '0;
            endcase
         end else begin
            for (int i = 0; i < NUM_CH; i++)
               if (w_sel_ch == 4'(i)) w_rdata = s_apb_addr[2] ? r_thr[i] : 32'(r_data[i]);
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_en
      assign sens_en[g] = (r_state == S_CONV) & ~r_empty & (r_ch == 4'(g));
   end

   assign s_apb_rdata  = w_rdata;
   assign s_apb_slverr = w_err;
   assign s_apb_ready  = 1'b1;
   assign irq          = r_irq;
endmodule

// File: tb/tb_apb_pvt_scan_ctrl.sv
// Scoreboard bench for apb_pvt_scan_ctrl: stimulus queues expected APB responses,
// sensor-enable rises and sampled checks; one negedge monitor pops and compares.
module tb_apb_pvt_scan_ctrl;
   localparam int NUM_CH = 8, DATA_W = 12, TIMEOUT = 20, AW = 7;

   logic                     clk = 1'b0, rst = 1'b1;
   logic [AW-1:0]            addr = '0;
   logic                     sel = 1'b0, enable = 1'b0, write = 1'b0;
   logic [31:0]              wdata = '0, rdata;
   logic                     ready, slverr, irq;
   logic [NUM_CH-1:0]        sens_en, sens_valid = '0;
   logic [NUM_CH*DATA_W-1:0] sens_data = '0;

   always #5 clk = ~clk;

   apb_pvt_scan_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .s_apb_clk(clk), .s_apb_rst(rst), .s_apb_addr(addr), .s_apb_sel(sel),
      .s_apb_enable(enable), .s_apb_write(write), .s_apb_wdata(wdata),
      .s_apb_wstrb(4'hF), .s_apb_rdata(rdata), .s_apb_ready(ready),
      .s_apb_slverr(slverr), .sens_en(sens_en), .sens_valid(sens_valid),
      .sens_data(sens_data), .irq(irq));

   typedef struct {string name; logic [31:0] data; logic err; bit chk;} exp_t;
   typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
   exp_t apb_q[$];
   chk_t chk_q[$];
   int   en_q[$];
   int   rise_t[$];
   int   hi_cnt[NUM_CH] = '{default: 0};
   int   n_vec = 0, n_miss = 0, cyc = 0;
   logic [NUM_CH-1:0] prev_en = '0;

   // Sensor model: answers dly cycles after its enable rises (dly 0 = never)
   int              dly[NUM_CH] = '{default: 0};
   logic [DATA_W-1:0] rsp[NUM_CH] = '{default: '0};
   int              scnt[NUM_CH] = '{default: 0};
   always @(negedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (sens_en[i]) scnt[i]++;
         else            scnt[i] = 0;
         sens_valid[i] = sens_en[i] && (dly[i] != 0) && (scnt[i] == dly[i]);
         sens_data[i*DATA_W +: DATA_W] = rsp[i];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      chk_t c;
      if (sel && enable) begin
         if (apb_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL apb_unexpected: access at 0x%02h, no expectation queued", addr);
         end else begin
            e = apb_q.pop_front();
            cmp({e.name, "_slverr"}, 32'(slverr), 32'(e.err));
            if (e.chk) cmp(e.name, rdata, e.data);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (sens_en[i]) hi_cnt[i]++;
         if (sens_en[i] && !prev_en[i]) begin
            if (i == 0) rise_t.push_back(cyc);
            if (en_q.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL sens_en_rise: unexpected rise on ch %0d, none expected", i);
            end else cmp("sens_en_rise_ch", 32'(i), 32'(en_q.pop_front()));
         end
      end
      prev_en = sens_en;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         cmp(c.name, c.act, c.exp);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_q.push_back('{name: nm, act: act, exp: exp});
   endtask

   task automatic apb_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic err, input string nm);
      apb_q.push_back('{name: nm, data: 32'h0, err: err, chk: 1'b0});
      addr = a; wdata = d; write = 1'b1; sel = 1'b1; enable = 1'b0;
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk); #1 sel = 1'b0; enable = 1'b0; write = 1'b0;
   endtask

   task automatic apb_rd(input logic [AW-1:0] a, input logic [31:0] exp, input logic err, input string nm);
      apb_q.push_back('{name: nm, data: exp, err: err, chk: !err});
      addr = a; write = 1'b0; sel = 1'b1; enable = 1'b0;
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk); #1 sel = 1'b0; enable = 1'b0;
   endtask

   typedef struct {logic [DATA_W-1:0] d; logic [31:0] stat;} thr_vec_t;
   thr_vec_t thr_tab[5];

   initial begin
      int snap, base, g0, g1;
      thr_tab[0] = '{12'h0FF, 32'h4000_0008};
      thr_tab[1] = '{12'h150, 32'h4000_0000};
      thr_tab[2] = '{12'h100, 32'h4000_0000};
      thr_tab[3] = '{12'h200, 32'h4000_0000};
      thr_tab[4] = '{12'h201, 32'h4000_0008};
      wait_cyc(3);
      rst = 1'b0;

      // T1: async reset in the middle of a conversion
      en_q.push_back(0);
      apb_wr(7'h00, 32'h0001_0003, 1'b0, "t1_ctrl");
      wait_cyc(3);
      check("t1_sens_en_busy", 32'(sens_en), 32'h1);
      rst = 1'b1;
      #1 check("t1_sens_en_async", 32'(sens_en), 32'h0);
      wait_cyc(2);
      rst = 1'b0;
      check("t1_irq", 32'(irq), 32'h0);
      apb_rd(7'h00, 32'h0, 1'b0, "t1_ctrl_rst");
      apb_rd(7'h04, 32'h0, 1'b0, "t1_status_rst");
      apb_rd(7'h08, 32'h0, 1'b0, "t1_period_rst");
      apb_rd(7'h0C, 32'h0, 1'b0, "t1_irqen_rst");
      apb_rd(7'h10, 32'h0, 1'b0, "t1_irqstat_rst");
      apb_rd(7'h20, 32'h0, 1'b0, "t1_data0_rst");
      apb_rd(7'h24, 32'hFFFF_0000, 1'b0, "t1_thr0_rst");
      apb_rd(7'h5C, 32'hFFFF_0000, 1'b0, "t1_thr7_rst");

      // T2: one-shot scan of ch0 and ch2
      for (int i = 0; i < NUM_CH; i++) begin dly[i] = 5; rsp[i] = 12'h123; end
      snap = hi_cnt[0];
      en_q.push_back(0); en_q.push_back(2);
      apb_wr(7'h00, 32'h0005_0003, 1'b0, "t2_ctrl");
      wait_cyc(20);
      check("t2_ch0_en_cycles", 32'(hi_cnt[0] - snap), 32'd5);
      apb_rd(7'h20, 32'h123, 1'b0, "t2_data0");
      apb_rd(7'h28, 32'h0, 1'b0, "t2_data1");
      apb_rd(7'h30, 32'h123, 1'b0, "t2_data2");
      apb_rd(7'h10, 32'h4000_0000, 1'b0, "t2_irqstat");
      apb_rd(7'h04, 32'h0000_0200, 1'b0, "t2_status");
      apb_rd(7'h00, 32'h0005_0001, 1'b0, "t2_ctrl_rd");
      apb_wr(7'h10, 32'hFFFF_FFFF, 1'b0, "t2_clr");

      // empty mask: done without any enable
      apb_wr(7'h00, 32'h0000_0003, 1'b0, "m0_ctrl");
      wait_cyc(5);
      apb_rd(7'h10, 32'h4000_0000, 1'b0, "m0_irqstat");
      apb_wr(7'h10, 32'hFFFF_FFFF, 1'b0, "m0_clr");

      // T3: threshold window on ch3 (lo 0x100, hi 0x200)
      apb_wr(7'h3C, 32'h0200_0100, 1'b0, "t3_thr3");
      apb_rd(7'h3C, 32'h0200_0100, 1'b0, "t3_thr3_rd");
      for (int k = 0; k < 5; k++) begin
         rsp[3] = thr_tab[k].d;
         en_q.push_back(3);
         apb_wr(7'h00, 32'h0008_0003, 1'b0, "t3_ctrl");
         wait_cyc(10);
         apb_rd(7'h10, thr_tab[k].stat, 1'b0, $sformatf("t3_irqstat_%03h", thr_tab[k].d));
         apb_rd(7'h38, 32'(thr_tab[k].d), 1'b0, "t3_data3");
         apb_wr(7'h10, 32'hFFFF_FFFF, 1'b0, "t3_clr");
      end
      apb_wr(7'h0C, 32'h0000_0008, 1'b0, "t3_irqen");
      rsp[3] = 12'h0FF;
      en_q.push_back(3);
      apb_wr(7'h00, 32'h0008_0003, 1'b0, "t3_ctrl_irq");
      wait_cyc(10);
      check("t3_irq_set", 32'(irq), 32'h1);
      apb_wr(7'h10, 32'h0000_0008, 1'b0, "t3_w1c");
      check("t3_irq_lag", 32'(irq), 32'h1);
      wait_cyc(1);
      check("t3_irq_clr", 32'(irq), 32'h0);
      apb_rd(7'h10, 32'h4000_0000, 1'b0, "t3_irqstat_after");
      apb_wr(7'h0C, 32'h0, 1'b0, "t3_irqen_off");
      apb_wr(7'h10, 32'hFFFF_FFFF, 1'b0, "t3_clr2");

      // T4: ch1 timeout keeps previous DATA
      rsp[1] = 12'h0AB;
      en_q.push_back(1);
      apb_wr(7'h00, 32'h0002_0003, 1'b0, "t4_ctrl_a");
      wait_cyc(10);
      apb_rd(7'h28, 32'h0AB, 1'b0, "t4_data1_a");
      apb_wr(7'h10, 32'hFFFF_FFFF, 1'b0, "t4_clr");
      dly[1] = 0; rsp[1] = 12'h777;
      snap = hi_cnt[1];
      en_q.push_back(1);
      apb_wr(7'h00, 32'h0002_0003, 1'b0, "t4_ctrl_b");
      wait_cyc(TIMEOUT + 8);
      check("t4_en_cycles", 32'(hi_cnt[1] - snap), 32'(TIMEOUT));
      apb_rd(7'h10, 32'h6000_0000, 1'b0, "t4_irqstat");
      apb_rd(7'h28, 32'h0AB, 1'b0, "t4_data1_kept");
      apb_wr(7'h10, 32'hFFFF_FFFF, 1'b0, "t4_clr2");

      // T5: periodic scan of ch0, PERIOD=10, stopped mid-wait
      apb_wr(7'h08, 32'd10, 1'b0, "t5_period");
      apb_rd(7'h08, 32'd10, 1'b0, "t5_period_rd");
      base = rise_t.size();
      repeat (3) en_q.push_back(0);
      apb_wr(7'h00, 32'h0001_0007, 1'b0, "t5_ctrl");
      wait_cyc(42);
      apb_wr(7'h00, 32'h0001_0004, 1'b0, "t5_stop");
      wait_cyc(40);
      g0 = -1; g1 = -1;
      if (rise_t.size() >= base + 3) begin
         g0 = rise_t[base+1] - rise_t[base];
         g1 = rise_t[base+2] - rise_t[base+1];
      end
      check("t5_rise_count", 32'(rise_t.size() - base), 32'd3);
      check("t5_period_gap0", 32'(g0), 32'd17);
      check("t5_period_gap1", 32'(g1), 32'd17);
      apb_rd(7'h04, 32'h0, 1'b0, "t5_status");
      apb_rd(7'h00, 32'h0001_0004, 1'b0, "t5_ctrl_rd");
      apb_rd(7'h10, 32'h4000_0000, 1'b0, "t5_irqstat");

      // T6: error responses leave state untouched
      apb_rd(7'h60, 32'h0, 1'b1, "t6_rd_bad_ch");
      apb_rd(7'h7C, 32'h0, 1'b1, "t6_rd_far_ch");
      apb_rd(7'h14, 32'h0, 1'b1, "t6_rd_hole");
      apb_wr(7'h04, 32'hFFFF_FFFF, 1'b1, "t6_wr_status");
      apb_wr(7'h14, 32'hFFFF_FFFF, 1'b1, "t6_wr_hole");
      apb_wr(7'h20, 32'h0000_0FFF, 1'b1, "t6_wr_data0");
      apb_wr(7'h64, 32'h1234_5678, 1'b1, "t6_wr_bad_thr");
      apb_rd(7'h04, 32'h0, 1'b0, "t6_status_same");
      apb_rd(7'h20, 32'h123, 1'b0, "t6_data0_same");
      apb_rd(7'h00, 32'h0001_0004, 1'b0, "t6_ctrl_same");

      wait_cyc(3);
      check("end_apb_queue_left", 32'(apb_q.size()), 32'd0);
      check("end_rise_queue_left", 32'(en_q.size()), 32'd0);
      wait_cyc(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
